counter_monitor: RTL and testbench
==================================

# counter_monitor

Receive-side checker for the free-running up-counter's `value` bus. It samples the counter output each qualified cycle and locks onto the +1 mod 2^WIDTH sequence. It then flags skipped or corrupted values, counts wraps and restarts-to-zero, and keeps saturating error statistics. It sits beside any counter instance in a bench or in silicon as a self-check on the counter's output stream.

## Interface
- `WIDTH`, default 8: counter value width.
- `LOCK_COUNT`, default 4: consecutive correct steps needed to declare lock (≥2).
- `ERR_LIMIT`, default 3: consecutive mismatches that drop lock (≥1).
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `valid` in 1: `value` is sampled on this cycle.
- `value` in WIDTH: observed counter output.
- `clear` in 1: synchronous clear of `err_count`, `wrap_count` and `restart_count`.
- `locked` out 1: monitor is in LOCKED or SLIP.
- `error` out 1: one-cycle pulse for each mismatched sample while locked.
- `restart` out 1: one-cycle pulse when the counter returns to 0 early (counter reset seen).
- `expected` out WIDTH: value predicted for the next valid sample.
- `err_count` out 16: mismatches, saturating at 16'hFFFF.
- `wrap_count` out 16: max→0 transitions, saturating.
- `restart_count` out 16: early returns to 0, saturating.

## Operation
- Values at reset: state SEEK, `expected` 0, all counts 0, all pulses 0, `locked` 0, run counters 0.
- Samples with `valid` = 0 are ignored entirely. The monitor state holds and the pulses stay 0.
- SEEK:
  - Each valid sample sets `expected` to `value`+1 mod 2^WIDTH.
  - If `value` equals the old `expected` and `good_run` > 0, `good_run` increments. Otherwise `good_run` is set to 1.
  - When `good_run` reaches LOCK_COUNT, the state moves to LOCKED and `good_run` clears.
  - No errors, wraps or restarts are counted in SEEK.
- LOCKED, on a valid sample:
  - `value` == `expected`: the sample is good. If `value` == 0, this is a wrap and `wrap_count` increments.
  - `value` == 0 and `expected` != 0: this is a restart. `restart` pulses, `restart_count` increments, `expected` becomes 1 and the state stays LOCKED.
  - Any other mismatch: `error` pulses, `err_count` increments, `miss_run` becomes 1, the state moves to SLIP, and `expected` becomes old `expected`+1 (the model free-runs).
- SLIP, on a valid sample:
  - Match: the state returns to LOCKED and `miss_run` clears. The wrap rule still applies.
  - A 0 that is not expected counts as a restart, with the same behaviour as in LOCKED; the state returns to LOCKED.
  - Any other mismatch: `error` pulses, `err_count` increments, `expected` advances by 1 and `miss_run` increments. When `miss_run` reaches ERR_LIMIT, the state moves to SEEK, `good_run` clears and `locked` drops.
- All `expected` arithmetic is mod 2^WIDTH. With the defaults, 8'hFF+1 = 8'h00.
- If `clear` and a counting event occur on the same cycle, `clear` wins: the count reads 0. The state machine and the pulses still process the sample.
- Saturated counts hold at 16'hFFFF until `clear` or `reset`.

## Timing
- All outputs are registered. A valid sample at edge N is reflected in `locked`, `error`, `restart`, `expected` and the counts after edge N.
- Pulses last exactly one cycle per event. Back-to-back events give back-to-back pulses.
- Latency from reset release to lock with a clean stream: LOCK_COUNT valid samples. With defaults, `locked` rises after the 4th valid sample.
- Asserting `reset` mid-operation clears everything immediately, independent of `clk`.

## Structure
- Shared package `counter_monitor_pkg` holds:
  - the state encoding SEEK=2'd0, LOCKED=2'd1, SLIP=2'd2;
  - the statistics width constant (16);
  - the saturation value.
- One sub-module, `sat_counter`: a 16-bit saturating counter with synchronous clear and increment enable. It is instantiated three times, with `clear` taking priority over increment.

## Test plan
- Reset release, then a clean stream 10,11,12,13,14: `locked` rises after 13 is sampled. `err_count`=0 and `expected`=15 after 14 is sampled.
- Locked stream …FE,FF,00,01: `wrap_count`=1, no `error`, `expected`=02.
- Locked stream 20,21,99,23,24: a single `error` pulse on 99, the state goes SLIP and then back to LOCKED on 23, and `err_count`=1.
- Locked stream 40,41,7,7,7: three `error` pulses, the state returns to SEEK, `locked` 0 and `err_count`=3.
- Locked at 57 followed by 0,1,2 (counter reset): `restart` pulses once, `restart_count`=1, no error, still locked.
- Run `clear` on a cycle with a wrap, then assert `reset` mid-SLIP: all counts read 0, then the state is SEEK and `expected`=0 with no clock edge needed.

Source files
------------

// File: rtl/counter_monitor_pkg.sv
// Shared definitions for the counter_monitor checker: state encoding and
// statistics counter sizing.
package counter_monitor_pkg;

    localparam logic [1:0] ST_SEEK   = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_SLIP   = 2'd2;

    localparam int STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_SAT = {STAT_W{1'b1}};

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at its maximum value; a synchronous clear
// takes priority over an increment on the same cycle.
module sat_counter
    import counter_monitor_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);

    logic [STAT_W-1:0] count_d;
    logic [STAT_W-1:0] count_q;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
        return (c == STAT_SAT) ? c : c + STAT_W'(1);
    endfunction

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = sat_inc(count_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_monitor.sv
// Receive-side checker for a free-running up-counter: locks onto the +1
// sequence, flags corrupted samples, and tracks wraps and counter restarts.
module counter_monitor
    import counter_monitor_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_LIMIT  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [WIDTH-1:0]  value,
    input  logic              clear,
    output logic              locked,
    output logic              error,
    output logic              restart,
    output logic [WIDTH-1:0]  expected,
    output logic [STAT_W-1:0] err_count,
    output logic [STAT_W-1:0] wrap_count,
    output logic [STAT_W-1:0] restart_count
);

    localparam int GR_W = $clog2(LOCK_COUNT + 1);
    localparam int MR_W = $clog2(ERR_LIMIT + 1);
    localparam logic [GR_W-1:0]  GR_ONE    = GR_W'(1);
    localparam logic [GR_W-1:0]  GR_TARGET = GR_W'(LOCK_COUNT);
    localparam logic [MR_W-1:0]  MR_ONE    = MR_W'(1);
    localparam logic [MR_W-1:0]  MR_LIMIT  = MR_W'(ERR_LIMIT);
    localparam logic [WIDTH-1:0] VAL_ONE   = WIDTH'(1);

    logic [1:0]       state_d, state_q;
    logic [WIDTH-1:0] expected_d, expected_q;
    logic [GR_W-1:0]  good_run_d, good_run_q;
    logic [MR_W-1:0]  miss_run_d, miss_run_q;
    logic             locked_d, locked_q;
    logic             error_d, error_q;
    logic             restart_d, restart_q;
    logic             err_inc, wrap_inc, restart_inc;
    logic             is_match, is_zero;
    logic [WIDTH-1:0] exp_next;

    assign is_match = (value == expected_q);
    assign is_zero  = (value == '0);
    assign exp_next = expected_q + VAL_ONE;

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        good_run_d  = good_run_q;
        miss_run_d  = miss_run_q;
        error_d     = 1'b0;
        restart_d   = 1'b0;
        err_inc     = 1'b0;
        wrap_inc    = 1'b0;
        restart_inc = 1'b0;

        if (valid) begin
            if (state_q == ST_SEEK) begin
                expected_d = value + VAL_ONE;
                if (is_match && (good_run_q != '0)) begin
                    good_run_d = good_run_q + GR_ONE;
                end else begin
                    good_run_d = GR_ONE;
                end
                if (good_run_d == GR_TARGET) begin
                    state_d    = ST_LOCKED;
                    good_run_d = '0;
                end
            end else if (is_match) begin
                // An expected zero is the natural max->0 rollover, not a restart.
                expected_d = exp_next;
                wrap_inc   = is_zero;
                state_d    = ST_LOCKED;
                miss_run_d = '0;
            end else if (is_zero) begin
                restart_d   = 1'b1;
                restart_inc = 1'b1;
                expected_d  = VAL_ONE;
                state_d     = ST_LOCKED;
                miss_run_d  = '0;
            end else begin
                // Keep free-running the prediction so a single glitch re-syncs.
                error_d    = 1'b1;
                err_inc    = 1'b1;
                expected_d = exp_next;
                miss_run_d = (state_q == ST_LOCKED) ? MR_ONE : miss_run_q + MR_ONE;
                if (miss_run_d >= MR_LIMIT) begin
                    state_d    = ST_SEEK;
                    good_run_d = '0;
                    miss_run_d = '0;
                end else begin
                    state_d = ST_SLIP;
                end
            end
        end

        locked_d = (state_d != ST_SEEK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_SEEK;
            expected_q <= '0;
            good_run_q <= '0;
            miss_run_q <= '0;
            locked_q   <= 1'b0;
            error_q    <= 1'b0;
            restart_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            good_run_q <= good_run_d;
            miss_run_q <= miss_run_d;
            locked_q   <= locked_d;
            error_q    <= error_d;
            restart_q  <= restart_d;
        end
    end

    sat_counter u_err_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clear (clear),
        .inc   (err_inc),
        .count (err_count)
    );

    sat_counter u_wrap_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clear (clear),
        .inc   (wrap_inc),
        .count (wrap_count)
    );

    sat_counter u_restart_cnt (
        .clk   (clk),
        .rst_n (reset),
        .clear (clear),
        .inc   (restart_inc),
        .count (restart_count)
    );

    assign locked   = locked_q;
    assign error    = error_q;
    assign restart  = restart_q;
    assign expected = expected_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: scripted vectors for the key scenarios, then a
// randomized counter stream and a restart-count saturation run against a model.
module tb_counter_monitor;

    localparam int W   = 8;
    localparam int LC  = 4;
    localparam int EL  = 3;
    localparam int MOD = 256;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid = 1'b0;
    logic        clear = 1'b0;
    logic [7:0]  value = 8'h00;
    logic        locked, error, restart;
    logic [7:0]  expected;
    logic [15:0] err_count, wrap_count, restart_count;

    always #5 clk = ~clk;

    counter_monitor #(.WIDTH(W), .LOCK_COUNT(LC), .ERR_LIMIT(EL)) dut (
        .clk           (clk),
        .reset         (reset_n),
        .valid         (valid),
        .value         (value),
        .clear         (clear),
        .locked        (locked),
        .error         (error),
        .restart       (restart),
        .expected      (expected),
        .err_count     (err_count),
        .wrap_count    (wrap_count),
        .restart_count (restart_count)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b1;

    // Reference model: mode 0 = hunting, 1 = locked, 2 = slipping
    int m_mode, m_exp, m_good, m_miss, m_err, m_wrap, m_rst;
    bit m_error, m_restart;

    typedef struct {
        bit         rst;
        bit         v;
        logic [7:0] val;
        bit         clr;
        bit         l, e, r;
        logic [7:0] ex;
        int         ec, wc, rc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sat_inc(input int c);
        return (c >= 65535) ? 65535 : c + 1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_exp = 0; m_good = 0; m_miss = 0;
        m_err = 0; m_wrap = 0; m_rst = 0;
        m_error = 0; m_restart = 0;
    endtask

    task automatic model_step(input bit v, input int val, input bit clr);
        bit ev_err, ev_wrap, ev_rst;
        ev_err = 0; ev_wrap = 0; ev_rst = 0;
        m_error = 0; m_restart = 0;
        if (v) begin
            if (m_mode == 0) begin
                m_good = (val == m_exp && m_good > 0) ? m_good + 1 : 1;
                m_exp = (val + 1) % MOD;
                if (m_good == LC) begin
                    m_mode = 1;
                    m_good = 0;
                end
            end else if (val == m_exp) begin
                if (val == 0) ev_wrap = 1;
                m_exp = (m_exp + 1) % MOD;
                m_mode = 1;
                m_miss = 0;
            end else if (val == 0) begin
                ev_rst = 1;
                m_restart = 1;
                m_exp = 1;
                m_mode = 1;
                m_miss = 0;
            end else begin
                ev_err = 1;
                m_error = 1;
                m_exp = (m_exp + 1) % MOD;
                m_miss = (m_mode == 1) ? 1 : m_miss + 1;
                if (m_miss >= EL) begin
                    m_mode = 0;
                    m_good = 0;
                    m_miss = 0;
                end else begin
                    m_mode = 2;
                end
            end
        end
        if (clr) begin
            m_err = 0; m_wrap = 0; m_rst = 0;
        end else begin
            if (ev_err)  m_err  = sat_inc(m_err);
            if (ev_wrap) m_wrap = sat_inc(m_wrap);
            if (ev_rst)  m_rst  = sat_inc(m_rst);
        end
    endtask

    task automatic compare_model();
        check("model_locked",  locked,        (m_mode != 0));
        check("model_error",   error,         m_error);
        check("model_restart", restart,       m_restart);
        check("model_expected", expected,     m_exp);
        check("model_err_count", err_count,   m_err);
        check("model_wrap_count", wrap_count, m_wrap);
        check("model_restart_count", restart_count, m_rst);
    endtask

    task automatic apply(input bit v, input logic [7:0] val, input bit clr);
        @(negedge clk);
        valid = v;
        value = val;
        clear = clr;
        @(posedge clk);
        #1;
        model_step(v, int'(val), clr);
        if (chk_en) compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid = 1'b0;
        clear = 1'b0;
        reset_n = 1'b0;
        model_reset();
        #2;
        check("reset_locked", locked, 0);
        check("reset_error", error, 0);
        check("reset_restart", restart, 0);
        check("reset_expected", expected, 0);
        check("reset_counts", {err_count, wrap_count | restart_count}, 0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic vec_t mk(input bit rst, input bit v, input logic [7:0] val, input bit clr,
                                input bit l, input bit e, input bit r, input logic [7:0] ex,
                                input int ec, input int wc, input int rc);
        vec_t t;
        t.rst = rst; t.v = v; t.val = val; t.clr = clr;
        t.l = l; t.e = e; t.r = r; t.ex = ex;
        t.ec = ec; t.wc = wc; t.rc = rc;
        return t;
    endfunction

    initial begin
        int c;
        bit v, clr;
        int r;
        logic [7:0] val;

        // rst v  val   clr l  e  r  exp    ec wc rc
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h10, 0, 0, 0, 0, 8'h11, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h11, 0, 0, 0, 0, 8'h12, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h12, 0, 0, 0, 0, 8'h13, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h13, 0, 1, 0, 0, 8'h14, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h14, 0, 1, 0, 0, 8'h15, 0, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hFC, 0, 0, 0, 0, 8'hFD, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hFD, 0, 0, 0, 0, 8'hFE, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hFE, 0, 0, 0, 0, 8'hFF, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hFF, 0, 1, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 8'h01, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h01, 0, 1, 0, 0, 8'h02, 0, 1, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h1C, 0, 0, 0, 0, 8'h1D, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h1D, 0, 0, 0, 0, 8'h1E, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h1E, 0, 0, 0, 0, 8'h1F, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h1F, 0, 1, 0, 0, 8'h20, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h20, 0, 1, 0, 0, 8'h21, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h21, 0, 1, 0, 0, 8'h22, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h55, 0, 1, 0, 0, 8'h22, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h99, 0, 1, 1, 0, 8'h23, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h23, 0, 1, 0, 0, 8'h24, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h24, 0, 1, 0, 0, 8'h25, 1, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h3C, 0, 0, 0, 0, 8'h3D, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h3D, 0, 0, 0, 0, 8'h3E, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h3E, 0, 0, 0, 0, 8'h3F, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h3F, 0, 1, 0, 0, 8'h40, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h40, 0, 1, 0, 0, 8'h41, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h41, 0, 1, 0, 0, 8'h42, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h07, 0, 1, 1, 0, 8'h43, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h07, 0, 1, 1, 0, 8'h44, 2, 0, 0));
        vecs.push_back(mk(0, 1, 8'h07, 0, 0, 1, 0, 8'h45, 3, 0, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h54, 0, 0, 0, 0, 8'h55, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h55, 0, 0, 0, 0, 8'h56, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h56, 0, 0, 0, 0, 8'h57, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h57, 0, 1, 0, 0, 8'h58, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 1, 8'h01, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h01, 0, 1, 0, 0, 8'h02, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h02, 0, 1, 0, 0, 8'h03, 0, 0, 1));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hFA, 0, 0, 0, 0, 8'hFB, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hFB, 0, 0, 0, 0, 8'hFC, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hFC, 0, 0, 0, 0, 8'hFD, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'hFD, 0, 1, 0, 0, 8'hFE, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h77, 0, 1, 1, 0, 8'hFF, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'hFF, 0, 1, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h00, 1, 1, 0, 0, 8'h01, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h55, 0, 1, 1, 0, 8'h02, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) begin
                do_reset();
            end else begin
                apply(vecs[i].v, vecs[i].val, vecs[i].clr);
                check($sformatf("vec%0d_locked", i),   locked,        vecs[i].l);
                check($sformatf("vec%0d_error", i),    error,         vecs[i].e);
                check($sformatf("vec%0d_restart", i),  restart,       vecs[i].r);
                check($sformatf("vec%0d_expected", i), expected,      vecs[i].ex);
                check($sformatf("vec%0d_err_cnt", i),  err_count,     vecs[i].ec);
                check($sformatf("vec%0d_wrap_cnt", i), wrap_count,    vecs[i].wc);
                check($sformatf("vec%0d_rst_cnt", i),  restart_count, vecs[i].rc);
            end
        end

        // Asynchronous reset while slipping, sampled before the next clock edge.
        #1 reset_n = 1'b0;
        #1;
        check("async_locked",   locked,    0);
        check("async_expected", expected,  0);
        check("async_err_cnt",  err_count, 0);
        check("async_error",    error,     0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized counter stream with glitches, skips, restarts and clears.
        c = $urandom_range(0, 255);
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 49) == 0);
            r = $urandom_range(0, 99);
            val = 8'(c);
            if (v) begin
                if (r < 80) begin
                    val = 8'(c);
                    c = (c + 1) % MOD;
                end else if (r < 88) begin
                    val = 8'($urandom_range(0, 255));
                    c = (c + 1) % MOD;
                end else if (r < 94) begin
                    val = 8'h00;
                    c = 1;
                end else begin
                    val = 8'((c + 1) % MOD);
                    c = (c + 2) % MOD;
                end
            end
            apply(v, val, clr);
        end

        // Drive restart_count into saturation with a stream of early zeros.
        do_reset();
        apply(1, 8'h10, 0);
        apply(1, 8'h11, 0);
        apply(1, 8'h12, 0);
        apply(1, 8'h13, 0);
        chk_en = 1'b0;
        for (int n = 0; n < 65540; n++) apply(1, 8'h00, 0);
        chk_en = 1'b1;
        compare_model();
        check("sat_restart_count", restart_count, 16'hFFFF);
        apply(1, 8'h00, 0);
        check("sat_hold", restart_count, 16'hFFFF);
        apply(1, 8'h00, 1);
        check("sat_clear", restart_count, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
